// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the skid-buffered pipeline stage: occupancy state encodings,
// the IF/ID idle instruction, and the state-to-occupancy decode.
package pipe_stage_skid_pkg;

  // Encoded as {main_vld, skid_vld}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    PSS_EMPTY = 2'b00,
    PSS_ONE   = 2'b10,
    PSS_FULL  = 2'b11
  } pss_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  function automatic logic [1:0] pss_occ(input pss_state_e s);
    case (s)
      PSS_ONE:  return 2'd1;
      PSS_FULL: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload channel between pipeline stages.
// The master drives vld/dat, the slave drives rdy.
interface pipe_stage_skid_if #(
  parameter int WIDTH = 64
);
  logic             vld;
  logic             rdy;
  logic [WIDTH-1:0] dat;

  modport master (output vld, output dat, input rdy);
  modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One payload slot: data and valid register with sync reset, load, and clear-to-idle.
// Single-cycle update. No flow control of its own; clear wins over load.
module pipe_stage_skid_slot #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_d, vld_q;
  logic [WIDTH-1:0] dat_d, dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clr_i) begin
      vld_d = 1'b0;
      dat_d = IDLE_VAL;
    end else if (load_i) begin
      vld_d = 1'b1;
      dat_d = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= IDLE_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage with a one-entry skid slot; 1-cycle latency, 1 transfer/cycle.
// up.rdy is decoded only from registered state (low when the skid slot is occupied).
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  pipe_stage_skid_if.slave   up,
  pipe_stage_skid_if.master  dn,
  input  logic               flush_i,
  output logic [1:0]         occ_o
);

  logic             main_vld, skid_vld;
  logic [WIDTH-1:0] main_dat, skid_dat, main_din;
  logic             main_load, main_clr, skid_load, skid_clr;
  logic             acc_in, acc_out;
  pss_state_e       state;

  // The two slot valid bits are the state register.
  assign state   = pss_state_e'({main_vld, skid_vld});
  assign acc_in  = up.vld & ~skid_vld;
  assign acc_out = main_vld & dn.rdy;

  pipe_stage_skid_slot #(.WIDTH(WIDTH), .IDLE_VAL(IDLE_VAL)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_load),
    .clr_i  (main_clr),
    .din_i  (main_din),
    .vld_o  (main_vld),
    .dat_o  (main_dat)
  );

  pipe_stage_skid_slot #(.WIDTH(WIDTH), .IDLE_VAL(IDLE_VAL)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .clr_i  (skid_clr),
    .din_i  (up.dat),
    .vld_o  (skid_vld),
    .dat_o  (skid_dat)
  );

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_din  = up.dat;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush_i) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        PSS_EMPTY: main_load = acc_in;
        PSS_ONE: begin
          if (acc_in && acc_out)  main_load = 1'b1;
          if (acc_in && !acc_out) skid_load = 1'b1;
          if (!acc_in && acc_out) main_clr  = 1'b1;
        end
        PSS_FULL: begin
          if (acc_out) begin
            main_load = 1'b1;
            main_din  = skid_dat;
            skid_clr  = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    up.rdy = ~skid_vld;
    dn.vld = main_vld;
    dn.dat = main_vld ? main_dat : IDLE_VAL;
    occ_o  = pss_occ(state);
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, streaming and randomized
// traffic checked against a queue-based model of a two-entry FIFO stage.
module tb_pipe_stage_skid;

  localparam int          W    = 64;
  localparam logic [W-1:0] IDLE = 64'h13;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] occ;

  pipe_stage_skid_if #(.WIDTH(W)) up_if ();
  pipe_stage_skid_if #(.WIDTH(W)) dn_if ();

  pipe_stage_skid #(.WIDTH(W), .IDLE_VAL(IDLE)) dut (
    .clk     (clk),
    .rst     (rst),
    .up      (up_if.slave),
    .dn      (dn_if.master),
    .flush_i (flush),
    .occ_o   (occ)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mq[$];

  typedef struct {
    logic         r;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         ev;
    logic [W-1:0] ed;
    logic         eir;
    logic [1:0]   eocc;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, and update the FIFO model.
  task automatic cycle(input logic r, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic fl);
    logic ain, aout;
    rst         = r;
    up_if.vld   = iv;
    up_if.dat   = d;
    dn_if.rdy   = ordy;
    flush       = fl;
    ain  = iv && (mq.size() < 2);
    aout = (mq.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (r || fl) mq.delete();
    else begin
      if (aout) void'(mq.pop_front());
      if (ain) mq.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] exp_d;
    exp_d = (mq.size() > 0) ? mq[0] : IDLE;
    chk({tag, "_out_valid"}, W'(dn_if.vld), W'(mq.size() > 0));
    chk({tag, "_out_data"},  dn_if.dat, exp_d);
    chk({tag, "_in_ready"},  W'(up_if.rdy), W'(mq.size() < 2));
    chk({tag, "_occ"},       W'(occ), W'(mq.size()));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    up_if.vld = 1'b0; up_if.dat = '0; dn_if.rdy = 1'b0;

    //         r   iv  d        ordy fl   ev  ed      eir eocc
    tbl[0]  = '{1, 1, 64'h55, 0, 0,  0, IDLE,   1, 0};
    tbl[1]  = '{1, 1, 64'h55, 0, 0,  0, IDLE,   1, 0};
    tbl[2]  = '{0, 1, 64'hA,  0, 0,  1, 64'hA,  1, 1};
    tbl[3]  = '{0, 1, 64'hB,  0, 0,  1, 64'hA,  0, 2};
    tbl[4]  = '{0, 1, 64'hC,  0, 0,  1, 64'hA,  0, 2};
    tbl[5]  = '{0, 0, 64'h0,  1, 0,  1, 64'hB,  1, 1};
    tbl[6]  = '{0, 0, 64'h0,  1, 0,  0, IDLE,   1, 0};
    tbl[7]  = '{0, 1, 64'h1A, 0, 0,  1, 64'h1A, 1, 1};
    tbl[8]  = '{0, 1, 64'h1B, 0, 0,  1, 64'h1A, 0, 2};
    tbl[9]  = '{0, 1, 64'hC,  0, 1,  0, IDLE,   1, 0};
    tbl[10] = '{0, 1, 64'h2A, 0, 0,  1, 64'h2A, 1, 1};
    tbl[11] = '{0, 1, 64'hC,  1, 1,  0, IDLE,   1, 0};
    tbl[12] = '{0, 0, 64'h0,  1, 0,  0, IDLE,   1, 0};
    tbl[13] = '{0, 1, 64'h3A, 0, 0,  1, 64'h3A, 1, 1};
    tbl[14] = '{0, 1, 64'h3B, 0, 0,  1, 64'h3A, 0, 2};
    tbl[15] = '{1, 1, 64'h3C, 1, 0,  0, IDLE,   1, 0};
    tbl[16] = '{0, 0, 64'h0,  0, 0,  0, IDLE,   1, 0};
    tbl[17] = '{0, 1, 64'h4A, 1, 0,  1, 64'h4A, 1, 1};
    tbl[18] = '{0, 1, 64'h4B, 1, 0,  1, 64'h4B, 1, 1};
    tbl[19] = '{0, 0, 64'h0,  1, 0,  0, IDLE,   1, 0};

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d_out_valid", i), W'(dn_if.vld), W'(tbl[i].ev));
      chk($sformatf("vec%0d_out_data", i),  dn_if.dat, tbl[i].ed);
      chk($sformatf("vec%0d_in_ready", i),  W'(up_if.rdy), W'(tbl[i].eir));
      chk($sformatf("vec%0d_occ", i),       W'(occ), W'(tbl[i].eocc));
    end

    // Back-to-back streaming: each payload visible right after its accept edge.
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b0, 1'b1, W'(k), 1'b1, 1'b0);
      chk($sformatf("stream%0d_data", k),  dn_if.dat, W'(k));
      chk($sformatf("stream%0d_valid", k), W'(dn_if.vld), W'(1));
      chk($sformatf("stream%0d_ready", k), W'(up_if.rdy), W'(1));
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("stream_drain_valid", W'(dn_if.vld), W'(0));
    chk("stream_drain_data",  dn_if.dat, IDLE);

    // Randomized valid/backpressure with occasional flush and reset.
    for (int n = 0; n < 10000; n++) begin
      logic         r, iv, ordy, fl;
      logic [W-1:0] d;
      r    = ($urandom_range(0, 499) == 0);
      fl   = ($urandom_range(0, 63) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = {$urandom, $urandom};
      cycle(r, iv, d, ordy, fl);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline stage register: the next-generation replacement for the fixed stall/flush inter-stage registers (IF/ID and peers). It carries an arbitrary-width payload between two core pipeline stages using valid/ready flow control, with a one-entry skid buffer so `in_ready` is a pure register output and the stage sustains one transfer per cycle. Synchronous flush discards held contents and presents a programmable idle payload (e.g. NOP) downstream.

## Interface
- `WIDTH`, 64: payload width in bits (pc+inst packed by instantiator).
- `IDLE_VAL`, `{WIDTH{1'b0}}`: value driven on `out_data` whenever `out_valid`=0.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: upstream payload valid.
- `in_ready` output 1: stage can accept; registered.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: payload held for downstream.
- `out_ready` input 1: downstream accepts.
- `out_data` output WIDTH: held payload, `IDLE_VAL` when invalid.
- `flush_i` input 1: discard all held and incoming payloads.
- `occ_o` output 2: occupancy 0/1/2 (debug/perf).

## Operation
- Storage: main slot (drives `out_*`) and skid slot; `in_ready` = !skid_valid.
- States (from `{main_valid, skid_valid}`): EMPTY (00), ONE (10), FULL (11); 01 unreachable.
- Accept-in = `in_valid & in_ready`; accept-out = `out_valid & out_ready`.
- EMPTY: accept-in -> ONE, main <= in_data.
- ONE: in & out -> ONE, main <= in_data; in only -> FULL, skid <= in_data; out only -> EMPTY, main <= IDLE_VAL; neither -> hold.
- FULL: `in_ready`=0; accept-out -> ONE, main <= skid; else hold.
- Payload order strictly FIFO; no loss, no duplication.
- Flush (highest priority after reset): next state EMPTY, main data <= IDLE_VAL, skid cleared; payload accepted in the flush cycle is discarded; an accept-out in the flush cycle still counts as delivered.
- Reset: `out_valid`=0, `out_data`=IDLE_VAL, `in_ready`=1, `occ_o`=0.
- Data registers not enabled when no transfer targets them (hold value, low power).

## Timing
- Latency: payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: 1 payload/cycle when `out_ready` held 1.
- `in_ready` deasserts in the cycle after the stage enters FULL and reasserts the cycle after the FULL->ONE drain; no combinational path from `out_ready` to `in_ready`.
- All outputs registered or decoded only from registered state; no combinational input-to-output path.
- Reset or flush asserted mid-transfer takes effect at that edge; the following cycle shows EMPTY.

## Structure
- Add to `defines.v`: state encodings `PSS_EMPTY/ONE/FULL` and `INST_NOP` (32'h0000_0013) used as `IDLE_VAL` component for IF/ID instantiation.
- One sub-module natural: `pipe_slot` (WIDTH-wide data + valid register with sync reset, load, clear-to-idle); instantiated twice.
- Instantiator packs/unpacks `{pc, inst}`; stall/flush vectors from ctrl map to `out_ready` / `flush_i`.

## Test plan
- Reset: hold `rst`=1 2 cycles with `in_valid`=1 -> `out_valid`=0, `out_data`=IDLE_VAL, `in_ready`=1, `occ_o`=0.
- Streaming: WIDTH=64, send 0x1..0x10 back-to-back with `out_ready`=1 -> outputs 0x1..0x10 one per cycle, 1-cycle latency, `in_ready` never drops.
- Skid: `out_ready`=0, send 0xA then 0xB -> `occ_o`=2, `in_ready`=0 next cycle; raise `out_ready` -> 0xA then 0xB delivered, `in_ready`=1 after first drain.
- Flush in FULL with `in_valid`=1 (0xC) -> next cycle `out_valid`=0, `out_data`=IDLE_VAL (0x13 for IDLE_VAL=64'h13), 0xC never appears.
- Random backpressure: 10k cycles random `in_valid`/`out_ready` -> scoreboard in-order match, no loss/duplicates, `occ_o` equals accepted-minus-delivered.
- Reset asserted while FULL -> next cycle EMPTY, outputs at reset values.
